lane_vld_collector: RTL and testbench

LANE_VLD_COLLECTOR -- requirements
Module: lane_vld_collector

---
 rtl/lane_vld_if.sv | 26 ++
 rtl/lane_vld_collector.sv | 165 ++++++++++++++++
 tb/tb_lane_vld_collector.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_vld_if.sv
// Lane-valid collector bus: per-lane valid flags in, one lane report at a time out.
// The master side is the collector and the slave side is the consumer/driver.
interface lane_vld_if #(
   parameter int SIZE = 8,
   parameter int TSW  = 32
);
   localparam int IDXW = $clog2(SIZE);

   logic [SIZE-1:0] vld_in;
   logic            clear;
   logic            out_valid;
   logic            out_ready;
   logic [IDXW-1:0] out_idx;
   logic [TSW-1:0]  out_ts;
   logic            all_done;

   modport master (
      input  vld_in, clear, out_ready,
      output out_valid, out_idx, out_ts, all_done
   );

   modport slave (
      output vld_in, clear, out_ready,
      input  out_valid, out_idx, out_ts, all_done
   );
endinterface

// File: rtl/lane_vld_collector.sv
// Captures the first rising of each lane's valid with a timestamp, then reports
// each captured lane exactly once through a round-robin valid/ready stream.
module lane_vld_lane #(
   parameter int TSW = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clear,
   input  logic           vld,
   input  logic           grant,
   input  logic [TSW-1:0] cnt,
   output logic           pend,
   output logic           pend_nxt,
   output logic           rep_nxt,
   output logic [TSW-1:0] ts_nxt
);
   logic           captured;
   logic           reported;
   logic           new_cap;
   logic [TSW-1:0] ts;

   assign new_cap  = vld & ~captured;
   assign pend     = captured & ~reported;
   assign rep_nxt  = reported | grant;
   // Look-ahead view so a lane captured on a transfer edge can win that edge.
   assign pend_nxt = (captured | new_cap) & ~rep_nxt;
   assign ts_nxt   = new_cap ? cnt : ts;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         captured <= 1'b0;
         reported <= 1'b0;
         ts       <= '0;
      end else if (clear) begin
         captured <= 1'b0;
         reported <= 1'b0;
         ts       <= '0;
      end else begin
         if (new_cap) begin
            captured <= 1'b1;
            ts       <= cnt;
         end
         if (grant)
            reported <= 1'b1;
      end
   end
endmodule

module lane_vld_collector #(
   parameter int SIZE = 8,
   parameter int TSW  = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   lane_vld_if.master bus
);
   localparam int IDXW = $clog2(SIZE);
   localparam logic [IDXW-1:0] LAST = IDXW'(SIZE - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] OFFER = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]                 state;
   logic [TSW-1:0]             cnt;
   logic [IDXW-1:0]            ptr;
   logic                       out_valid;
   logic [IDXW-1:0]            out_idx;
   logic [TSW-1:0]             out_ts;
   logic                       xfer;
   logic [SIZE-1:0]            pend;
   logic [SIZE-1:0]            pend_nxt;
   logic [SIZE-1:0]            rep_nxt;
   logic [SIZE-1:0]            grant;
   logic [SIZE-1:0][TSW-1:0]   ts_nxt;
   logic [IDXW-1:0]            win_cur;
   logic [IDXW-1:0]            win_nxt;

   // First requester strictly after ptr, wrapping; ptr itself is checked last.
   function automatic logic [IDXW-1:0] rr_pick(input logic [SIZE-1:0] req,
                                               input logic [IDXW-1:0] p);
      logic [IDXW-1:0] sel;
      logic [IDXW-1:0] res;
      logic            found;
      res   = '0;
      found = 1'b0;
      for (int k = 1; k <= SIZE; k++) begin
         sel = IDXW'((int'(p) + k) % SIZE);
         if (!found && req[sel]) begin
            res   = sel;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   assign xfer = out_valid & bus.out_ready;

   for (genvar i = 0; i < SIZE; i++) begin : gen_lane
      assign grant[i] = xfer & (out_idx == IDXW'(i));
      lane_vld_lane #(.TSW(TSW)) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .clear    (bus.clear),
         .vld      (bus.vld_in[i]),
         .grant    (grant[i]),
         .cnt      (cnt),
         .pend     (pend[i]),
         .pend_nxt (pend_nxt[i]),
         .rep_nxt  (rep_nxt[i]),
         .ts_nxt   (ts_nxt[i])
      );
   end

   assign win_cur = rr_pick(pend, ptr);
   assign win_nxt = rr_pick(pend_nxt, out_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         ptr       <= LAST;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_ts    <= '0;
      end else if (bus.clear) begin
         state     <= IDLE;
         cnt       <= '0;
         ptr       <= LAST;
         out_valid <= 1'b0;
      end else begin
         cnt <= cnt + TSW'(1);
         case (state)
            IDLE: begin
               if (|pend) begin
                  state     <= OFFER;
                  out_valid <= 1'b1;
                  out_idx   <= win_cur;
                  out_ts    <= ts_nxt[win_cur];
               end
            end
            OFFER: begin
               // Offer is held untouched until the consumer takes it.
               if (xfer) begin
                  ptr <= out_idx;
                  if (|pend_nxt) begin
                     out_idx <= win_nxt;
                     out_ts  <= ts_nxt[win_nxt];
                  end else begin
                     out_valid <= 1'b0;
                     state     <= (&rep_nxt) ? DONE : IDLE;
                  end
               end
            end
            DONE: ;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.out_valid = out_valid;
   assign bus.out_idx   = out_idx;
   assign bus.out_ts    = out_ts;
   assign bus.all_done  = (state == DONE);
endmodule

// File: tb/tb_lane_vld_collector.sv
// Self-checking bench for lane_vld_collector: a table of single-shot lane masks
// plus hand sequences for stall, round-robin, clear and async reset.
module tb_lane_vld_collector;
   localparam int SIZE = 8;
   localparam int TSW  = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lane_vld_if #(.SIZE(SIZE), .TSW(TSW)) bus ();
   lane_vld_collector #(.SIZE(SIZE), .TSW(TSW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [2:0]  idx;
      logic [31:0] ts;
   } rep_t;

   typedef struct {
      logic [7:0] mask;
      logic       done;
   } vec_t;

   rep_t exp_q[$];
   int   rep_cyc[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   base  = 0;
   vec_t vt[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic push(input int idx, input int ts);
      rep_t e;
      e.idx = 3'(idx);
      e.ts  = ts;
      exp_q.push_back(e);
   endtask

   // One clock: sample a handshake on the falling edge, then step past the rising edge.
   task automatic tick();
      rep_t e;
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready && !bus.clear) begin
         rep_cyc.push_back(cyc - base);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_report: got idx %0d ts %0d want none", bus.out_idx, bus.out_ts);
         end else begin
            e = exp_q.pop_front();
            chk("rep_idx", 32'(bus.out_idx), 32'(e.idx));
            chk("rep_ts", bus.out_ts, e.ts);
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      base = cyc;
      rep_cyc.delete();
      exp_q.delete();
   endtask

   task automatic run_ramp(input bit use_clear);
      if (use_clear) begin
         bus.vld_in    = '0;
         bus.out_ready = 1'b1;
         do_clear();
      end
      for (int i = 0; i < 8; i++) begin
         bus.vld_in = bus.vld_in | (8'(1) << i);
         push(i, i);
         tick();
      end
      tick();
      tick();
      #3;
      chk("ramp_all_done", 32'(bus.all_done), 1);
      chk("ramp_nrep", rep_cyc.size(), 8);
      for (int j = 0; j < rep_cyc.size(); j++)
         chk("ramp_cyc", rep_cyc[j], j + 2);
      chk("ramp_q_empty", exp_q.size(), 0);
   endtask

   initial begin
      int n;
      logic [2:0] bi;
      vt[0] = '{mask: 8'hFF, done: 1'b1};
      vt[1] = '{mask: 8'h01, done: 1'b0};
      vt[2] = '{mask: 8'h80, done: 1'b0};
      vt[3] = '{mask: 8'hA5, done: 1'b0};
      vt[4] = '{mask: 8'h3C, done: 1'b0};

      bus.vld_in    = '0;
      bus.clear     = 1'b0;
      bus.out_ready = 1'b0;
      #12;
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_idx", 32'(bus.out_idx), 0);
      chk("rst_ts", bus.out_ts, 0);
      chk("rst_done", 32'(bus.all_done), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table: mask raised at cycle 0, reports in ascending lane order, no gaps.
      for (int v = 0; v < 5; v++) begin
         n = $countones(vt[v].mask);
         bus.vld_in    = '0;
         bus.out_ready = 1'b1;
         do_clear();
         bus.vld_in = vt[v].mask;
         for (int b = 0; b < 8; b++) begin
            bi = 3'(b);
            if (vt[v].mask[bi]) push(b, 0);
         end
         for (int c = 0; c < n + 2; c++) tick();
         #3;
         chk("tbl_done", 32'(bus.all_done), 32'(vt[v].done));
         chk("tbl_valid_low", 32'(bus.out_valid), 0);
         chk("tbl_nrep", rep_cyc.size(), n);
         for (int j = 0; j < rep_cyc.size(); j++)
            chk("tbl_cyc", rep_cyc[j], j + 2);
         chk("tbl_q_empty", exp_q.size(), 0);
      end

      // Staggered capture: lane i at cnt==i.
      run_ramp(1'b1);

      // Stall: lane 3 held while lane 1 captures behind it.
      bus.vld_in    = '0;
      bus.out_ready = 1'b0;
      do_clear();
      bus.vld_in = 8'h08;
      push(3, 0);
      tick();
      tick();
      bus.vld_in = 8'h0A;
      push(1, 2);
      for (int k = 0; k < 3; k++) begin
         #3;
         chk("stall_valid", 32'(bus.out_valid), 1);
         chk("stall_idx", 32'(bus.out_idx), 3);
         chk("stall_ts", bus.out_ts, 0);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      tick();
      #3;
      chk("stall_valid_low", 32'(bus.out_valid), 0);
      chk("stall_nrep", rep_cyc.size(), 2);
      for (int j = 0; j < rep_cyc.size(); j++)
         chk("stall_cyc", rep_cyc[j], j + 5);
      chk("stall_q_empty", exp_q.size(), 0);

      // Round robin: after 2,5 the pointer sits at 5 so 6 beats 1.
      bus.vld_in    = '0;
      bus.out_ready = 1'b1;
      do_clear();
      bus.vld_in = 8'h24;
      push(2, 0);
      push(5, 0);
      for (int k = 0; k < 6; k++) tick();
      bus.vld_in = 8'h66;
      push(6, 6);
      push(1, 6);
      for (int k = 0; k < 4; k++) tick();
      #3;
      chk("rr_valid_low", 32'(bus.out_valid), 0);
      chk("rr_nrep", rep_cyc.size(), 4);
      if (rep_cyc.size() == 4) begin
         chk("rr_cyc0", rep_cyc[0], 2);
         chk("rr_cyc1", rep_cyc[1], 3);
         chk("rr_cyc2", rep_cyc[2], 8);
         chk("rr_cyc3", rep_cyc[3], 9);
      end
      chk("rr_q_empty", exp_q.size(), 0);

      // Clear on the lane 4 handshake edge discards the report.
      bus.vld_in    = '0;
      bus.out_ready = 1'b1;
      do_clear();
      bus.vld_in = 8'h10;
      tick();
      tick();
      #3;
      chk("clr_pre_valid", 32'(bus.out_valid), 1);
      chk("clr_pre_idx", 32'(bus.out_idx), 4);
      do_clear();
      #3;
      chk("clr_valid", 32'(bus.out_valid), 0);
      chk("clr_done", 32'(bus.all_done), 0);
      push(4, 0);
      tick();
      tick();
      tick();
      chk("clr_nrep", rep_cyc.size(), 1);
      if (rep_cyc.size() == 1) chk("clr_cyc", rep_cyc[0], 2);
      chk("clr_q_empty", exp_q.size(), 0);

      // Async reset in the middle of an offer.
      bus.vld_in    = '0;
      bus.out_ready = 1'b0;
      do_clear();
      tick();
      bus.vld_in = 8'h10;
      tick();
      tick();
      #1;
      chk("ar_pre_valid", 32'(bus.out_valid), 1);
      chk("ar_pre_idx", 32'(bus.out_idx), 4);
      chk("ar_pre_ts", bus.out_ts, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(bus.out_valid), 0);
      chk("ar_idx", 32'(bus.out_idx), 0);
      chk("ar_ts", bus.out_ts, 0);
      chk("ar_done", 32'(bus.all_done), 0);
      tick();
      bus.vld_in = '0;
      tick();
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      base = cyc;
      rep_cyc.delete();
      exp_q.delete();
      run_ramp(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
